// File: rtl/sigdelay_multitap.sv
// Multi-tap delay line over a circular sample buffer: each accepted sample is written, then N_TAPS delayed reads are returned.
// Define SIGDELAY_MIX_EN to add the mix_signal port carrying the sum of all taps.
module sigdelay_multitap #(
    parameter int A_WIDTH = 9,
    parameter int D_WIDTH = 8,
    parameter int N_TAPS  = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sample_valid,
    output logic                        sample_ready,
    input  logic [D_WIDTH-1:0]          mic_signal,
    input  logic [N_TAPS*A_WIDTH-1:0]   offset,
    output logic [N_TAPS*D_WIDTH-1:0]   tap_out,
    output logic                        out_valid
`ifdef SIGDELAY_MIX_EN
    ,
    output logic [D_WIDTH+$clog2(N_TAPS):0] mix_signal
`endif
);

    localparam int IDX_W = (N_TAPS > 1) ? $clog2(N_TAPS) : 1;
    localparam int DEPTH = 1 << A_WIDTH;

    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;

    state_t                      r_state;
    state_t                      w_state_nxt;

    logic [D_WIDTH-1:0]          r_ram [DEPTH];
    logic [D_WIDTH-1:0]          r_sample;
    logic [N_TAPS*A_WIDTH-1:0]   r_offset;
    logic [A_WIDTH-1:0]          r_wr_ptr;
    logic [A_WIDTH-1:0]          r_fill_cnt;
    logic [IDX_W-1:0]            r_idx;
    logic [D_WIDTH-1:0]          r_rd_data;
    logic                        r_rd_zero;
    logic [D_WIDTH-1:0]          r_tap [N_TAPS];

    logic [A_WIDTH-1:0]          w_tap_off;
    logic [A_WIDTH-1:0]          w_rd_addr;
    logic [D_WIDTH-1:0]          w_rd_val;
    logic                        w_accept;
    logic                        w_we;
    logic                        w_last;

    assign w_accept  = sample_valid && sample_ready;
    assign w_last    = (r_idx == IDX_W'(N_TAPS - 1));
    assign w_tap_off = r_offset[r_idx*A_WIDTH +: A_WIDTH];
    assign w_rd_addr = r_wr_ptr - w_tap_off;
    assign w_rd_val  = r_rd_zero ? '0 : r_rd_data;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (sample_valid) w_state_nxt = WRITE;
            WRITE:   w_state_nxt = READ;
            READ:    if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        sample_ready = (r_state == IDLE);
        out_valid    = (r_state == DONE);
        w_we         = (r_state == WRITE);
    end

    // Buffer has no reset; stale contents are masked because fill_cnt restarts at 0.
    always_ff @(posedge clk) begin
        if (w_we) r_ram[r_wr_ptr] <= r_sample;
        if (r_state == READ) begin
            r_rd_data <= r_ram[w_rd_addr];
            r_rd_zero <= (w_tap_off > r_fill_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sample   <= '0;
            r_offset   <= '0;
            r_wr_ptr   <= '0;
            r_fill_cnt <= '0;
            r_idx      <= '0;
            for (int unsigned i = 0; i < N_TAPS; i++) r_tap[i] <= '0;
        end else begin
            if (w_accept) begin
                r_sample <= mic_signal;
                r_offset <= offset;
            end
            case (r_state)
                WRITE: r_idx <= '0;
                READ: begin
                    r_idx <= r_idx + 1'b1;
                    if (r_idx != '0) r_tap[r_idx - 1'b1] <= w_rd_val;
                end
                DONE: begin
                    r_tap[N_TAPS-1] <= w_rd_val;
                    r_wr_ptr        <= r_wr_ptr + 1'b1;
                    if (r_fill_cnt != '1) r_fill_cnt <= r_fill_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Last tap is passed straight through during DONE so out_valid and tap_out coincide.
    always_comb begin
        tap_out = '0;
        for (int unsigned i = 0; i < N_TAPS; i++) tap_out[i*D_WIDTH +: D_WIDTH] = r_tap[i];
        if (r_state == DONE) tap_out[(N_TAPS-1)*D_WIDTH +: D_WIDTH] = w_rd_val;
    end

`ifdef SIGDELAY_MIX_EN
    localparam int MIX_W = D_WIDTH + $clog2(N_TAPS) + 1;

    always_comb begin
        mix_signal = '0;
        for (int unsigned i = 0; i < N_TAPS; i++)
            mix_signal = mix_signal + {{(MIX_W-D_WIDTH){1'b0}}, tap_out[i*D_WIDTH +: D_WIDTH]};
    end
`endif

endmodule

// File: tb/tb_sigdelay_multitap.sv
// Directed testbench for sigdelay_multitap: default instance plus a 16-deep single-tap instance for wrap checks.
module tb_sigdelay_multitap;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        sample_valid;
    logic        sample_ready;
    logic [7:0]  mic_signal;
    logic [35:0] offset;
    logic [31:0] tap_out;
    logic        out_valid;

    logic        v4;
    logic        rdy4;
    logic [7:0]  mic4;
    logic [3:0]  off4;
    logic [7:0]  tap4;
    logic        ov4;

`ifdef SIGDELAY_MIX_EN
    logic [10:0] mix_signal;
    logic [8:0]  mix4;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    sigdelay_multitap #(.A_WIDTH(9), .D_WIDTH(8), .N_TAPS(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .mic_signal   (mic_signal),
        .offset       (offset),
        .tap_out      (tap_out),
        .out_valid    (out_valid)
`ifdef SIGDELAY_MIX_EN
        ,
        .mix_signal   (mix_signal)
`endif
    );

    sigdelay_multitap #(.A_WIDTH(4), .D_WIDTH(8), .N_TAPS(1)) dut4 (
        .clk          (clk),
        .rst          (rst),
        .sample_valid (v4),
        .sample_ready (rdy4),
        .mic_signal   (mic4),
        .offset       (off4),
        .tap_out      (tap4),
        .out_valid    (ov4)
`ifdef SIGDELAY_MIX_EN
        ,
        .mix_signal   (mix4)
`endif
    );

    task automatic send_and_wait(input logic [7:0] d, input logic [35:0] offs,
                                 output logic [31:0] taps, output int lat);
        int guard;
        guard = 0;
        lat   = 0;
        taps  = '0;
        @(negedge clk);
        while (!sample_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        sample_valid = 1'b1;
        mic_signal   = d;
        offset       = offs;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        offset       = ~offs;
        mic_signal   = ~d;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (out_valid) begin
                lat  = k;
                taps = tap_out;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (tap_out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_tap_out: got %h expected %h", tap_out, 32'h0);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_out_valid: got %b expected 0", out_valid);
        end
        n_checks++;
        if (tap4 !== 8'h0) begin
            n_fail++;
            $display("FAIL reset_tap4: got %h expected 00", tap4);
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (sample_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", sample_ready);
        end
    endtask

    task automatic test_sequence();
        logic [31:0] exp_taps [4];
        logic [31:0] taps;
        int          lat;
        int          exp_mix [4];
        exp_taps[0] = 32'h00000001;
        exp_taps[1] = 32'h00000102;
        exp_taps[2] = 32'h00010203;
        exp_taps[3] = 32'h01020304;
        exp_mix[0] = 1; exp_mix[1] = 3; exp_mix[2] = 6; exp_mix[3] = 10;
        for (int i = 0; i < 4; i++) begin
            send_and_wait(8'(i + 1), {9'd3, 9'd2, 9'd1, 9'd0}, taps, lat);
            n_checks++;
            if (taps !== exp_taps[i]) begin
                n_fail++;
                $display("FAIL seq_taps[%0d]: got %h expected %h", i, taps, exp_taps[i]);
            end
            n_checks++;
            if (lat != 6) begin
                n_fail++;
                $display("FAIL seq_latency[%0d]: got %0d expected 6", i, lat);
            end
`ifdef SIGDELAY_MIX_EN
            n_checks++;
            if (mix_signal !== 11'(exp_mix[i])) begin
                n_fail++;
                $display("FAIL seq_mix[%0d]: got %0d expected %0d", i, mix_signal, exp_mix[i]);
            end
`endif
        end
    endtask

    task automatic test_latency();
        int   guard;
        logic exp_ov;
        logic exp_rdy;
        guard = 0;
        @(negedge clk);
        while (!sample_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        sample_valid = 1'b1;
        mic_signal   = 8'd5;
        offset       = {9'd4, 9'd0, 9'd1, 9'd2};
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        offset       = '1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            exp_ov  = (k == 6);
            exp_rdy = (k >= 7);
            n_checks++;
            if (out_valid !== exp_ov) begin
                n_fail++;
                $display("FAIL lat_out_valid[k=%0d]: got %b expected %b", k, out_valid, exp_ov);
            end
            n_checks++;
            if (sample_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL lat_ready[k=%0d]: got %b expected %b", k, sample_ready, exp_rdy);
            end
            if (k >= 6) begin
                n_checks++;
                if (tap_out !== 32'h01050403) begin
                    n_fail++;
                    $display("FAIL lat_taps_hold[k=%0d]: got %h expected %h", k, tap_out, 32'h01050403);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_taps [3];
        int          pulses;
        int          last_n;
        int          n_sent;
        exp_taps[0] = 32'h0304050A;
        exp_taps[1] = 32'h04050A0B;
        exp_taps[2] = 32'h050A0B0C;
        pulses = 0;
        last_n = 0;
        n_sent = 0;
        offset = {9'd3, 9'd2, 9'd1, 9'd0};
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (out_valid) begin
                if (pulses < 3) begin
                    n_checks++;
                    if (tap_out !== exp_taps[pulses]) begin
                        n_fail++;
                        $display("FAIL b2b_taps[%0d]: got %h expected %h", pulses, tap_out, exp_taps[pulses]);
                    end
                end
                if (pulses > 0) begin
                    n_checks++;
                    if (n - last_n != 7) begin
                        n_fail++;
                        $display("FAIL b2b_interval[%0d]: got %0d expected 7", pulses, n - last_n);
                    end
                end
                last_n = n;
                pulses++;
            end
            if (sample_ready) begin
                if (n_sent < 3) begin
                    sample_valid = 1'b1;
                    mic_signal   = 8'(10 + n_sent);
                    n_sent++;
                end else begin
                    sample_valid = 1'b0;
                end
            end
        end
        sample_valid = 1'b0;
        n_checks++;
        if (pulses != 3) begin
            n_fail++;
            $display("FAIL b2b_pulse_count: got %0d expected 3", pulses);
        end
    endtask

    task automatic test_reset_mid();
        int          guard;
        int          stray;
        logic [31:0] taps;
        int          lat;
        guard = 0;
        stray = 0;
        @(negedge clk);
        while (!sample_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        sample_valid = 1'b1;
        mic_signal   = 8'd99;
        offset       = '0;
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if (tap_out !== 32'h0) begin
            n_fail++;
            $display("FAIL rmid_tap_out: got %h expected %h", tap_out, 32'h0);
        end
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rmid_out_valid: got %b expected 0", out_valid);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (out_valid) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL rmid_stray_pulses: got %0d expected 0", stray);
        end
        send_and_wait(8'd7, {9'd0, 9'd0, 9'd0, 9'd1}, taps, lat);
        n_checks++;
        if (taps !== 32'h07070700) begin
            n_fail++;
            $display("FAIL rmid_next_taps: got %h expected %h", taps, 32'h07070700);
        end
        n_checks++;
        if (lat != 6) begin
            n_fail++;
            $display("FAIL rmid_next_latency: got %0d expected 6", lat);
        end
    endtask

`ifdef SIGDELAY_MIX_EN
    task automatic test_mix();
        logic [31:0] taps;
        int          lat;
        send_and_wait(8'd255, '0, taps, lat);
        n_checks++;
        if (taps !== 32'hFFFFFFFF) begin
            n_fail++;
            $display("FAIL mix_taps: got %h expected %h", taps, 32'hFFFFFFFF);
        end
        n_checks++;
        if (mix_signal !== 11'd1020) begin
            n_fail++;
            $display("FAIL mix_sum: got %0d expected 1020", mix_signal);
        end
    endtask
`endif

    task automatic test_wrap();
        int         guard;
        int         lat;
        logic [7:0] got;
        logic [7:0] exp_v;
        for (int k = 1; k <= 20; k++) begin
            guard = 0;
            @(negedge clk);
            while (!rdy4 && guard < 50) begin
                @(negedge clk);
                guard++;
            end
            v4   = 1'b1;
            mic4 = 8'(k);
            off4 = 4'd15;
            @(posedge clk);
            #1;
            v4   = 1'b0;
            off4 = 4'd0;
            lat  = 0;
            got  = 8'hEE;
            for (int j = 1; j <= 10; j++) begin
                @(negedge clk);
                if (ov4) begin
                    lat = j;
                    got = tap4;
                    break;
                end
            end
            exp_v = (k <= 15) ? 8'd0 : 8'(k - 15);
            n_checks++;
            if (got !== exp_v) begin
                n_fail++;
                $display("FAIL wrap_tap0[sample %0d]: got %0d expected %0d", k, got, exp_v);
            end
`ifdef SIGDELAY_MIX_EN
            n_checks++;
            if (mix4 !== {1'b0, exp_v}) begin
                n_fail++;
                $display("FAIL wrap_mix[sample %0d]: got %0d expected %0d", k, mix4, exp_v);
            end
`endif
            if (k == 1) begin
                n_checks++;
                if (lat != 3) begin
                    n_fail++;
                    $display("FAIL wrap_latency: got %0d expected 3", lat);
                end
            end
        end
    endtask

    initial begin
        rst          = 1'b0;
        sample_valid = 1'b0;
        mic_signal   = '0;
        offset       = '0;
        v4           = 1'b0;
        mic4         = '0;
        off4         = '0;
        test_reset();
        test_sequence();
        test_latency();
        test_back_to_back();
        test_reset_mid();
`ifdef SIGDELAY_MIX_EN
        test_mix();
`endif
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sigdelay_multitap.md
SIGDELAY_MULTITAP -- requirements
Module: sigdelay_multitap

Interface
REQ-001 SHALL have parameter A_WIDTH, default 9: buffer address width; depth = 2^A_WIDTH samples.
REQ-002 SHALL have parameter D_WIDTH, default 8: sample width, unsigned.
REQ-003 SHALL have parameter N_TAPS, default 4: number of delay taps, legal range 1..8.
REQ-004 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1: reset, asynchronous, active-low.
REQ-006 SHALL have port sample_valid  input  1: input sample present.
REQ-007 SHALL have port sample_ready  output  1: block can accept a sample this cycle.
REQ-008 SHALL have port mic_signal  input  D_WIDTH: input sample.
REQ-009 SHALL have port offset  input  N_TAPS*A_WIDTH: packed per-tap delay in samples; tap i occupies bits [i*A_WIDTH +: A_WIDTH].
REQ-010 SHALL have port tap_out  output  N_TAPS*D_WIDTH: packed delayed samples, same packing as offset.
REQ-011 SHALL have port out_valid  output  1: one-cycle pulse; tap_out was updated this cycle.
REQ-012 SHALL have port mix_signal  output  D_WIDTH+$clog2(N_TAPS)+1: sum of taps; present only when SIGDELAY_MIX_EN is defined.

Function
REQ-013 SHALL store samples in an internal dual-port RAM with synchronous write and registered read (1-cycle read latency), addressed by a wrapping write pointer wr_ptr.
REQ-014 SHALL implement FSM states IDLE, WRITE, READ, DONE; sample_ready SHALL be 1 only in IDLE.
REQ-015 IDLE -> WRITE on the edge where sample_valid && sample_ready; mic_signal and offset SHALL be latched on that edge.
REQ-016 WRITE SHALL write the latched sample to RAM[wr_ptr] for one cycle, then go to READ with tap index 0.
REQ-017 READ SHALL issue read address (wr_ptr - offset_i) mod 2^A_WIDTH for tap i = 0..N_TAPS-1, one tap per cycle, capturing each result one cycle later; after tap N_TAPS-1 go to DONE.
REQ-018 DONE SHALL capture the last tap, assert out_valid for exactly one cycle with all tap_out fields updated, increment wr_ptr (wrap 2^A_WIDTH-1 -> 0), increment fill_cnt, and return to IDLE.
REQ-019 Latency: out_valid SHALL be high exactly N_TAPS+2 cycles after the accepting edge; next sample_ready SHALL be high the cycle after out_valid.
REQ-020 offset_i = 0 SHALL return the current sample (write precedes read).
REQ-021 fill_cnt SHALL count samples stored before the current one, saturating at 2^A_WIDTH-1; tap i SHALL output 0 when offset_i > fill_cnt (unwritten location).
REQ-022 sample_valid while sample_ready = 0 SHALL be ignored; no sample is stored and state is unaffected.
REQ-023 offset changes after the accepting edge SHALL not affect the current sample's taps.
REQ-024 tap_out SHALL hold its value between out_valid pulses.

Reset
REQ-025 rst low SHALL immediately force FSM to IDLE, wr_ptr = 0, fill_cnt = 0, tap_out = 0, out_valid = 0, mix_signal = 0, sample_ready = 1 after release.
REQ-026 Reset mid-operation SHALL abort the sample with no out_valid pulse; RAM contents are don't-care and SHALL be masked by fill_cnt = 0.

Configuration
REQ-027 With SIGDELAY_MIX_EN defined, mix_signal SHALL equal the unsigned sum of all N_TAPS tap values, updated in the same cycle as out_valid, no overflow at full width.
REQ-028 Without SIGDELAY_MIX_EN, the mix_signal port and adder logic SHALL be absent; all other behaviour identical.

Verification
REQ-029 Reset then samples 1,2,3,... with offsets {0,1,2,3} -> first out_valid: tap_out {1,0,0,0}; fourth: {4,3,2,1}.
REQ-030 Single sample accepted at edge t, N_TAPS=4 -> out_valid high only at cycle t+6, sample_ready low t+1..t+6.
REQ-031 A_WIDTH=4, offset_0=15, write 20 samples 1..20 -> tap_0 = 0 for samples 1..15, tap_0 = 1 at sample 16, tap_0 = 5 at sample 20 (wrap).
REQ-032 Hold sample_valid high continuously -> exactly one sample accepted per N_TAPS+3 cycles, none lost or duplicated.
REQ-033 Assert rst during READ -> no out_valid, all outputs 0; next sample with offset 1 -> tap 0.
REQ-034 SIGDELAY_MIX_EN, D_WIDTH=8, all taps 255 -> mix_signal = 1020; build without macro -> port absent, taps unchanged.
